ibex_star_mac_acc: RTL
======================

Name: ibex_star_mac_acc

Overview:
Multi-cycle, multi-precision signed sub-word MAC engine with a persistent accumulator bank. It executes the STAR md_op_e operations (bit 6 = 1, plus MACRST) for the Ibex EX stage. It generalises the fixed-pass STAR multiplier with a parametrised number of multipliers (passes per op), accumulator width and optional saturation. Commits are atomic, so a flush never leaves partial sums.

Parameters:
AccWidth, 32, width of each of the 8 bank words; 64-bit accumulators use word pairs {acc[2k+1],acc[2k]}.
NumMul, 8, lane products per cycle; legal values 1, 2, 4, 8.
Saturate, 0, when 1 the AccWidth-wide SA accumulators (8b and 4b) saturate on signed overflow.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
req_i  in  1  operation request
ready_o  out  1  high only in IDLE
kill_i  in  1  abort the in-flight op (EX flush)
op_i  in  7  md_op_e encoding
op_a_i  in  32  packed signed lanes
op_b_i  in  32  packed signed lanes
valid_o  out  1  one-cycle result strobe
result_o  out  32  result, valid when valid_o=1
sat_o  out  1  sticky saturation flag
illegal_o  out  1  one-cycle strobe for a non-STAR op

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE; all bank words 0; shadow sums 0; ready_o=1; valid_o=0; result_o=0; sat_o=0; illegal_o=0. Reset overrides any in-flight op.
- Decode: precision from op[5:4]: 00=16b (2 lanes), 01=8b (4 lanes), 11=4b (8 lanes). op[3]=0 is ST, op[3]=1 is SA. Lane i occupies bits [i*W+W-1 : i*W]. All lanes are signed.
- Passes: P = ceil(lanes/NumMul). NumMul=8 gives P=1. 4b with NumMul=1 gives P=8.
- FSM IDLE -> BUSY -> DONE -> IDLE.
  - IDLE: on req_i, latch op and operands, clear the shadow, pass counter=0, go to BUSY.
  - BUSY: each cycle, multiply lanes [cnt*NumMul, cnt*NumMul+NumMul-1] and add them into the shadow (the ST shadow is one 64-bit sum; the SA shadow is per lane). On cnt==P-1, commit shadow + bank to the bank in a single write and go to DONE.
  - DONE: valid_o=1 and result_o is driven from the updated bank; go to IDLE.
  - Latency: valid_o rises P+1 cycles after the accept edge.
- ST: acc64 {acc1,acc0} += sign-extended sum of lane products, with wrap. Without op[2], result is the low 32 bits; with op[2] (MAC16ST_H), the high 32 bits.
- SA 16b: lane k accumulates into pair k, with wrap. Result is pair op[0], low half or high half by op[2].
- SA 8b / 4b: lane k product is sign-extended to AccWidth and added to acc[k]. Result is acc[op[1:0]] or acc[op[2:0]].
  - Saturate=1: on signed overflow, clamp to the AccWidth max/min and set sat_o.
  - Saturate=0: wrap.
- MACRST (0111111): on accept, clear the bank and sat_o; DONE follows the next cycle with result_o=0. Latency is 2 cycles regardless of P.
- Any op with op[6]=0 other than MACRST: bank untouched, illegal_o=1 and valid_o=1 with result_o=0, both 2 cycles after accept.
- kill_i in BUSY: go to IDLE next cycle with no commit and no valid_o. kill_i in DONE: ignored, since the commit is already done. kill_i in IDLE: no effect; a req_i in the same cycle is not accepted.
- req_i while not ready_o: ignored, and the requester must hold it.
- Precision change without MACRST: bank words are reinterpreted raw. This is defined, not an error.
- ST ops never set sat_o.

Decomposition:
- ibex_pkg gains:
  - mac_prec_e {MAC_PREC_16, MAC_PREC_8, MAC_PREC_4}
  - localparams MD_STAR_BIT=6, MD_SA_BIT=3, MD_HI_BIT=2
  - MD_OP_MACRST reuse
  - a mac_state_e {MAC_IDLE, MAC_BUSY, MAC_DONE}
- Sub-module ibex_star_mac_lane: one signed 16x16 multiplier that sign-extends 8b/4b lane slices according to precision. NumMul instances are used.

Test Plan:
- MAC8SA x2, a=b=0x7F7F7F7F, Saturate=1, AccWidth=8 -> acc[0..3]=127, sat_o=1, result_o=0x7F.
- MAC16ST with a=0x00030002, b=0x00050004 -> result 23 (2*4+3*5); then MAC16ST_H -> 0. NumMul=1: valid_o 3 cycles after accept.
- MAC4SA_L7, a=0xF0000000 (lane7=-1), b=0x30000000 (lane7=3), NumMul=2 -> result 0xFFFFFFFD; valid_o at cycle 5.
- MAC8ST accepted, then kill_i in the 2nd BUSY cycle (NumMul=1) -> no valid_o, bank unchanged; the next MAC8SA returns the pre-kill value plus its own product.
- MACRST after saturation -> result_o=0, sat_o=0, all banks 0; op MD_OP_MUL -> illegal_o=1, valid_o=1, result_o=0.
- rst_i asserted mid-BUSY -> next cycle ready_o=1, bank 0, valid_o stays 0.

Source files
------------

// File: rtl/ibex_star_mac_acc_pkg.sv
// Shared types, opcode fields and decode helpers for the STAR sub-word MAC accumulator.
package ibex_star_mac_acc_pkg;

  localparam int unsigned MD_OP_W     = 7;
  localparam int unsigned MD_STAR_BIT = 6;
  localparam int unsigned MD_SA_BIT   = 3;
  localparam int unsigned MD_HI_BIT   = 2;
  localparam int unsigned NUM_ACC     = 8;
  localparam int unsigned LANE_W      = 16;
  localparam int unsigned PROD_W      = 32;
  localparam int unsigned DATA_W      = 32;

  localparam logic [MD_OP_W-1:0] MD_OP_MACRST = 7'b0111111;
  localparam logic [MD_OP_W-1:0] MD_OP_MUL    = 7'b0000000;

  typedef enum logic [1:0] {
    MAC_PREC_16 = 2'b00,
    MAC_PREC_8  = 2'b01,
    MAC_PREC_4  = 2'b11
  } mac_prec_e;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_BUSY = 2'd1,
    MAC_DONE = 2'd2
  } mac_state_e;

  typedef enum logic [1:0] {
    MAC_KIND_STAR = 2'd0,
    MAC_KIND_RST  = 2'd1,
    MAC_KIND_ILL  = 2'd2
  } mac_kind_e;

  typedef struct packed {
    mac_kind_e  kind;
    mac_prec_e  prec;
    logic       sa;
    logic       hi;
    logic [2:0] sel;
  } mac_cmd_t;

  // Precision encoding 2'b10 has no lane layout, so it is treated as illegal.
  function automatic mac_cmd_t mac_decode(input logic [MD_OP_W-1:0] op);
    mac_cmd_t cmd;
    cmd.kind = MAC_KIND_ILL;
    cmd.prec = MAC_PREC_16;
    cmd.sa   = op[MD_SA_BIT];
    cmd.hi   = op[MD_HI_BIT];
    cmd.sel  = op[2:0];
    if (op == MD_OP_MACRST) begin
      cmd.kind = MAC_KIND_RST;
    end else if (op[MD_STAR_BIT] && (op[5:4] != 2'b10)) begin
      cmd.kind = MAC_KIND_STAR;
      cmd.prec = mac_prec_e'(op[5:4]);
    end
    return cmd;
  endfunction

  function automatic int unsigned mac_lanes(input mac_prec_e prec);
    case (prec)
      MAC_PREC_16: return 2;
      MAC_PREC_8:  return 4;
      default:     return 8;
    endcase
  endfunction

  function automatic int unsigned mac_lane_w(input mac_prec_e prec);
    case (prec)
      MAC_PREC_16: return 16;
      MAC_PREC_8:  return 8;
      default:     return 4;
    endcase
  endfunction

endpackage

// File: rtl/ibex_star_mac_acc_lane.sv
// One signed 16x16 lane multiplier; narrower lanes are sign-extended from the low slice bits.
module ibex_star_mac_acc_lane
  import ibex_star_mac_acc_pkg::*;
(
  input  mac_prec_e                 prec_i,
  input  logic [LANE_W-1:0]         a_i,
  input  logic [LANE_W-1:0]         b_i,
  input  logic                      en_i,
  output logic signed [PROD_W-1:0]  prod_c
);

  logic signed [LANE_W-1:0] a_ext;
  logic signed [LANE_W-1:0] b_ext;

  always_comb begin
    a_ext = a_i;
    b_ext = b_i;
    case (prec_i)
      MAC_PREC_8: begin
        a_ext = {{8{a_i[7]}}, a_i[7:0]};
        b_ext = {{8{b_i[7]}}, b_i[7:0]};
      end
      MAC_PREC_4: begin
        a_ext = {{12{a_i[3]}}, a_i[3:0]};
        b_ext = {{12{b_i[3]}}, b_i[3:0]};
      end
      default: begin
        a_ext = a_i;
        b_ext = b_i;
      end
    endcase
  end

  // Gated lanes contribute zero so the caller can sum all lanes unconditionally.
  assign prod_c = en_i ? (PROD_W'(a_ext) * PROD_W'(b_ext)) : '0;

endmodule

// File: rtl/ibex_star_mac_acc.sv
// Multi-pass signed sub-word MAC with a persistent 8-word accumulator bank and atomic commit.
module ibex_star_mac_acc
  import ibex_star_mac_acc_pkg::*;
#(
  parameter int unsigned AccWidth = 32,
  parameter int unsigned NumMul   = 8,
  parameter bit          Saturate = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  output logic                ready_o,
  input  logic                kill_i,
  input  logic [MD_OP_W-1:0]  op_i,
  input  logic [DATA_W-1:0]   op_a_i,
  input  logic [DATA_W-1:0]   op_b_i,
  output logic                valid_o,
  output logic [DATA_W-1:0]   result_o,
  output logic                sat_o,
  output logic                illegal_o
);

  localparam int unsigned PairW = 2 * AccWidth;
  localparam int unsigned SumW  = ((AccWidth > PROD_W) ? AccWidth : PROD_W) + 1;
  localparam int unsigned CntW  = 3;
  localparam int unsigned IdxW  = 6;
  localparam int unsigned ShW   = 7;

  mac_state_e                state_q, state_d;
  mac_cmd_t                  cmd_q, cmd_d;
  logic [DATA_W-1:0]         op_a_q, op_a_d;
  logic [DATA_W-1:0]         op_b_q, op_b_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic signed [63:0]        st_sh_q, st_sh_d;
  logic signed [PROD_W-1:0]  sa_sh_q [NUM_ACC];
  logic signed [PROD_W-1:0]  sa_sh_d [NUM_ACC];
  logic [AccWidth-1:0]       bank_q [NUM_ACC];
  logic [AccWidth-1:0]       bank_d [NUM_ACC];
  logic                      sat_q, sat_d;
  logic                      ready_q, ready_d;
  logic                      valid_q, valid_d;
  logic                      ill_q, ill_d;
  logic [DATA_W-1:0]         result_q, result_d;

  logic                              accept;
  logic                              last_pass;
  int unsigned                       passes;
  logic [NumMul-1:0][IdxW-1:0]       lane_idx;
  logic [NumMul-1:0][ShW-1:0]        lane_sh;
  logic [NumMul-1:0][LANE_W-1:0]     lane_a;
  logic [NumMul-1:0][LANE_W-1:0]     lane_b;
  logic [NumMul-1:0]                 lane_en;
  logic [NumMul-1:0][PROD_W-1:0]     lane_prod;
  logic [PairW-1:0]                  pair_tmp;
  logic signed [SumW-1:0]            wide_tmp;
  logic                              ovf_tmp;
  logic [AccWidth-1:0]               word_tmp;

  assign accept = (state_q == MAC_IDLE) && req_i && !kill_i;

  // Pass bookkeeping: non-STAR ops spend exactly one BUSY cycle.
  always_comb begin
    passes    = (mac_lanes(cmd_q.prec) + NumMul - 1) / NumMul;
    last_pass = (cmd_q.kind != MAC_KIND_STAR) || ((32'(cnt_q) + 32'd1) >= passes);
  end

  // Lane slice selection for the current pass.
  always_comb begin
    lane_idx = '0;
    lane_sh  = '0;
    lane_a   = '0;
    lane_b   = '0;
    lane_en  = '0;
    for (int unsigned j = 0; j < NumMul; j++) begin
      lane_idx[j] = IdxW'(cnt_q) * IdxW'(NumMul) + IdxW'(j);
      lane_sh[j]  = ShW'(lane_idx[j]) * ShW'(mac_lane_w(cmd_q.prec));
      lane_a[j]   = LANE_W'(op_a_q >> lane_sh[j]);
      lane_b[j]   = LANE_W'(op_b_q >> lane_sh[j]);
      lane_en[j]  = (state_q == MAC_BUSY) && (cmd_q.kind == MAC_KIND_STAR) &&
                    (32'(lane_idx[j]) < mac_lanes(cmd_q.prec));
    end
  end

  for (genvar j = 0; j < NumMul; j++) begin : g_lane
    ibex_star_mac_acc_lane u_lane (
      .prec_i (cmd_q.prec),
      .a_i    (lane_a[j]),
      .b_i    (lane_b[j]),
      .en_i   (lane_en[j]),
      .prod_c (lane_prod[j])
    );
  end

  // Next-state, shadow accumulation, single-write commit and output staging.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    cnt_d    = cnt_q;
    st_sh_d  = st_sh_q;
    sa_sh_d  = sa_sh_q;
    bank_d   = bank_q;
    sat_d    = sat_q;
    valid_d  = 1'b0;
    ill_d    = 1'b0;
    result_d = '0;
    pair_tmp = '0;
    wide_tmp = '0;
    ovf_tmp  = 1'b0;
    word_tmp = '0;

    unique case (state_q)
      MAC_IDLE: begin
        if (accept) begin
          cmd_d   = mac_decode(op_i);
          op_a_d  = op_a_i;
          op_b_d  = op_b_i;
          cnt_d   = '0;
          st_sh_d = '0;
          for (int unsigned k = 0; k < NUM_ACC; k++) sa_sh_d[k] = '0;
          if (cmd_d.kind == MAC_KIND_RST) begin
            for (int unsigned k = 0; k < NUM_ACC; k++) bank_d[k] = '0;
            sat_d = 1'b0;
          end
          state_d = MAC_BUSY;
        end
      end

      MAC_BUSY: begin
        if (kill_i) begin
          state_d = MAC_IDLE;
        end else begin
          for (int unsigned j = 0; j < NumMul; j++) begin
            if (lane_en[j]) begin
              st_sh_d = st_sh_d + 64'($signed(lane_prod[j]));
              sa_sh_d[lane_idx[j][2:0]] = $signed(lane_prod[j]);
            end
          end
          if (last_pass) begin
            if (cmd_q.kind == MAC_KIND_STAR) begin
              if (!cmd_q.sa) begin
                pair_tmp  = {bank_q[1], bank_q[0]} + PairW'(st_sh_d);
                bank_d[1] = pair_tmp[PairW-1:AccWidth];
                bank_d[0] = pair_tmp[AccWidth-1:0];
              end else if (cmd_q.prec == MAC_PREC_16) begin
                for (int unsigned k = 0; k < 2; k++) begin
                  pair_tmp      = {bank_q[2*k+1], bank_q[2*k]} + PairW'(sa_sh_d[k]);
                  bank_d[2*k+1] = pair_tmp[PairW-1:AccWidth];
                  bank_d[2*k]   = pair_tmp[AccWidth-1:0];
                end
              end else begin
                // Exact-width sum, then clamp or wrap back to AccWidth.
                for (int unsigned k = 0; k < NUM_ACC; k++) begin
                  if (k < mac_lanes(cmd_q.prec)) begin
                    wide_tmp = SumW'($signed(bank_q[k])) + SumW'(sa_sh_d[k]);
                    ovf_tmp  = (wide_tmp != SumW'($signed(wide_tmp[AccWidth-1:0])));
                    if (Saturate && ovf_tmp) begin
                      bank_d[k] = wide_tmp[SumW-1] ? {1'b1, {(AccWidth-1){1'b0}}}
                                                   : {1'b0, {(AccWidth-1){1'b1}}};
                      sat_d     = 1'b1;
                    end else begin
                      bank_d[k] = wide_tmp[AccWidth-1:0];
                    end
                  end
                end
              end
            end
            state_d = MAC_DONE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      MAC_DONE: begin
        valid_d = 1'b1;
        ill_d   = (cmd_q.kind == MAC_KIND_ILL);
        if (cmd_q.kind == MAC_KIND_STAR) begin
          if (!cmd_q.sa) begin
            word_tmp = cmd_q.hi ? bank_q[1] : bank_q[0];
          end else if (cmd_q.prec == MAC_PREC_16) begin
            word_tmp = bank_q[{1'b0, cmd_q.sel[0], cmd_q.hi}];
          end else if (cmd_q.prec == MAC_PREC_8) begin
            word_tmp = bank_q[{1'b0, cmd_q.sel[1:0]}];
          end else begin
            word_tmp = bank_q[cmd_q.sel];
          end
          result_d = DATA_W'($signed(word_tmp));
        end
        state_d = MAC_IDLE;
      end

      default: state_d = MAC_IDLE;
    endcase

    ready_d = (state_d == MAC_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MAC_IDLE;
      cmd_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      cnt_q    <= '0;
      st_sh_q  <= '0;
      for (int unsigned k = 0; k < NUM_ACC; k++) begin
        sa_sh_q[k] <= '0;
        bank_q[k]  <= '0;
      end
      sat_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      ill_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      cnt_q    <= cnt_d;
      st_sh_q  <= st_sh_d;
      sa_sh_q  <= sa_sh_d;
      bank_q   <= bank_d;
      sat_q    <= sat_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      ill_q    <= ill_d;
      result_q <= result_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign sat_o     = sat_q;
  assign illegal_o = ill_q;

endmodule
